// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants for the divider and result mux
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int ALU_WIDTH = 16;
    localparam int DIV_ITERS = 16;

    localparam logic [3:0] CMD_DIV = 4'd4;
    localparam logic [3:0] CMD_MOD = 4'd5;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;

    // The extra top bit of trial is the borrow of the subtraction.
    assign shifted = {rem_in, dvd_bit};
    assign trial   = shifted - {2'b00, divisor};
    assign borrow  = trial[WIDTH+1];

    assign q_bit   = ~borrow;
    assign rem_out = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 16-cycle restoring divider, signed mode under DIV_SIGNED_EN
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             error
);

    div_state_t       state, state_nx;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [4:0]       cnt;
    logic             divz;

    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic             last;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             ovf_final;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .dvd_bit (dvd[WIDTH-1]),
        .divisor (dsr),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign last  = (cnt == 5'(DIV_ITERS - 1));
    assign q_raw = {dvd[WIDTH-2:0], step_q};

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r, ovf;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign mag_a = inputA[WIDTH-1] ? (~inputA + WIDTH'(1)) : inputA;
    assign mag_b = inputB[WIDTH-1] ? (~inputB + WIDTH'(1)) : inputB;
    // A zero divisor keeps the raw dividend so it can be returned as the remainder.
    assign op_a  = (inputB == '0) ? inputA : mag_a;
    assign op_b  = mag_b;

    assign q_final   = neg_q ? ('0 - q_raw) : q_raw;
    assign r_final   = neg_r ? ('0 - step_rem[WIDTH-1:0]) : step_rem[WIDTH-1:0];
    assign ovf_final = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= inputA[WIDTH-1] ^ inputB[WIDTH-1];
            neg_r <= inputA[WIDTH-1];
            ovf   <= (inputA == {1'b1, {(WIDTH-1){1'b0}}}) && (inputB == '1);
        end
    end
`else
    assign op_a      = inputA;
    assign op_b      = inputB;
    assign q_final   = q_raw;
    assign r_final   = step_rem[WIDTH-1:0];
    assign ovf_final = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (divz || last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            cnt       <= '0;
            divz      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dvd   <= op_a;
                    dsr   <= op_b;
                    rem   <= '0;
                    cnt   <= '0;
                    divz  <= (inputB == '0);
                    error <= 1'b0;
                end
                CALC: if (divz) begin
                    quotient  <= '1;
                    remainder <= dvd;
                    error     <= 1'b1;
                end else begin
                    rem <= step_rem;
                    dvd <= q_raw;
                    cnt <= cnt + 5'd1;
                    if (last) begin
                        quotient  <= q_final;
                        remainder <= r_final;
                        error     <= ovf_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed-vector bench for seq_divider
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] inputA = '0;
    logic [15:0] inputB = '0;
    logic        busy, done, error;
    logic [15:0] quotient, remainder;

    int n_vec = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .inputA    (inputA),
        .inputB    (inputB),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eq, input logic [15:0] er,
                           input logic ee, input int elat);
        int lat;
        @(negedge clk);
        inputA = a;
        inputB = b;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, busy, 1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, ".lat"}, lat, elat);
        check({tag, ".q"}, quotient, eq);
        check({tag, ".r"}, remainder, er);
        check({tag, ".err"}, error, ee);
        @(negedge clk);
        check({tag, ".done_end"}, done, 0);
        check({tag, ".busy_end"}, busy, 0);
    endtask

    initial begin
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.q", quotient, 0);
        check("rst.r", remainder, 0);
        check("rst.err", error, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("d2047", 16'd2047, 16'd511, 16'd4, 16'd3, 1'b0, 16);
        run_div("dz", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1);
        run_div("dmax", 16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, 16);
        run_div("dsmall", 16'd5, 16'd65535, 16'd0, 16'd5, 1'b0, 16);

        // Start pulses during CALC must be ignored.
        @(negedge clk);
        inputA = 16'd100;
        inputB = 16'd7;
        start  = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 3 || i == 16) begin
                start  = 1'b1;
                inputA = 16'd5;
                inputB = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        check("ign.done", done, 1);
        check("ign.busy", busy, 1);
        check("ign.q", quotient, 16'd14);
        check("ign.r", remainder, 16'd2);
        @(negedge clk);
        check("ign.idle", busy, 0);

        // Async reset in the middle of a division.
        @(negedge clk);
        inputA = 16'd100;
        inputB = 16'd7;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid.busy", busy, 0);
        check("mid.done", done, 0);
        check("mid.q", quotient, 0);
        check("mid.r", remainder, 0);
        check("mid.err", error, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div("after_rst", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 16);

`ifdef DIV_SIGNED_EN
        run_div("s_neg7", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 16);
        run_div("s_ovf", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1, 16);
        run_div("s_dz", 16'hFFF9, 16'd0, 16'hFFFF, 16'hFFF9, 1'b1, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
